// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: W = 4*NIBBLES operands summed one nibble per clock
// through a 4-bit ripple adder, with the carry registered between nibbles.

module four_bitadderD (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       cout_o
);
    logic [4:0] c;

    assign c[0] = cin_i;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign cout_o = c[4];
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 c_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic          c_out_q, c_out_d;
    logic          ovf_q, ovf_d;

    logic [3:0]    add_s;
    logic          add_co;
    logic [W-1:0]  acc_shift;

    four_bitadderD u_add (
        .a_i   (a_q[3:0]),
        .b_i   (b_q[3:0]),
        .cin_i (carry_q),
        .s_o   (add_s),
        .cout_o(add_co)
    );

    // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
    assign acc_shift = (acc_q >> 4) | (W'(add_s) << (W - 4));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    carry_d = c_in;
                    idx_d   = '0;
                    a_msb_d = a[W-1];
                    b_msb_d = b[W-1];
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                acc_d   = acc_shift;
                carry_d = add_co;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    // Published result only updates here, so it holds across later ops.
                    sum_d   = acc_shift;
                    c_out_d = add_co;
                    ovf_d   = (a_msb_q == b_msb_q) && (add_s[3] != a_msb_q);
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_ADD);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 16-bit build and a 4-bit build share clock and reset.

module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_ready, c_in = 1'b0;
    logic [15:0] a = '0, b = '0, sum;
    logic        out_valid, out_ready = 1'b0, c_out, ovf, busy;

    logic        in_valid1 = 1'b0, in_ready1, c_in1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0, sum1;
    logic        out_valid1, out_ready1 = 1'b0, c_out1, ovf1, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .c_in(c_in1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .c_out(c_out1), .ovf(ovf1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, optionally scramble inputs during ADD, check latency and result.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic [15:0] es, input logic ec,
                          input logic eo, input bit scramble);
        a = av; b = bv; c_in = ci; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 1; i < 4; i++) begin
            if (scramble) begin a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; end
            step();
            chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        end
        step();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(c_out), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
        chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout_ovf", {30'd0, c_out, ovf}, 32'd0);
        rst_n = 1'b1;
        step();

        run_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("cin",     16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b1);

        // Backpressure: result held while new operands wait at the input.
        a = 16'h1111; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
        step();
        a = 16'h0F0F; b = 16'h0101;
        repeat (4) step();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_sum", 32'(sum), 32'h3333);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sum", 32'(sum), 32'h3333);
            chk("bp_hold_flags", {29'd0, c_out, ovf, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);
        step();
        in_valid = 1'b0;
        chk("bp_next_accept", 32'(busy), 32'd1);
        repeat (4) step();
        chk("bp_next_sum", 32'(sum), 32'h1010);
        chk("bp_next_flags", {30'd0, c_out, ovf}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset mid-ADD at idx=2 clears outputs immediately.
        a = 16'h7777; b = 16'h1111; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid_busy", {30'd0, out_valid, busy}, 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_flags", {30'd0, c_out, ovf}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("mid_rst_no_partial", 32'(out_valid), 32'd0);

        // Single-nibble build: ADD lasts one cycle.
        a1 = 4'hF; b1 = 4'h1; c_in1 = 1'b0; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        chk("n1_busy", 32'(busy1), 32'd1);
        step();
        chk("n1_valid", 32'(out_valid1), 32'd1);
        chk("n1_sum", 32'(sum1), 32'h0);
        chk("n1_flags", {30'd0, c_out1, ovf1}, 32'd2);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        a1 = 4'h7; b1 = 4'h1; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        step();
        chk("n1_ovf_sum", 32'(sum1), 32'h8);
        chk("n1_ovf_flags", {30'd0, c_out1, ovf1}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-word adder front end: accepts two 4*NIBBLES-bit operands over a valid/ready handshake and processes one nibble per clock through an internal four_bitadderD instance.
- Nibble carry-out is registered and fed back as the next nibble's carry-in; result nibbles are assembled into a sum register.
- Lets the datapath add 16-bit (default) operands using the existing 4-bit ripple adder, trading latency for area.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, c_in valid this cycle
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- c_in  input  1  carry into nibble 0
- out_valid  output  1  sum, c_out, ovf valid
- out_ready  input  1  consumer accepts result
- sum  output  W  result
- c_out  output  1  carry out of the top nibble
- ovf  output  1  signed (two's-complement) overflow
- busy  output  1  high while in ADD state

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE; in_ready=1; out_valid=0; busy=0; sum=0; c_out=0; ovf=0.
  - Internal operand shift registers, carry register and nibble index are all cleared.
  - Any operation in flight is discarded; no partial result is ever presented.
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: register a and b into shift registers, carry_reg=c_in, idx=0, latch the sign bits a[W-1] and b[W-1], go to ADD.
  - in_valid=0 keeps the block in IDLE.
- ADD:
  - in_ready=0, busy=1.
  - The four_bitadderD instance is driven by the low nibble of each shift register plus carry_reg.
  - Each edge: shift the adder's sum nibble into the top of the sum register (shift right by 4), shift both operand registers right by 4, carry_reg = adder carry out, idx++.
  - When idx reaches NIBBLES-1 on an edge: go to DONE and register c_out = that nibble's carry out.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - ovf = (latched a_msb == latched b_msb) && (sum[W-1] != latched a_msb), registered on entry to DONE.
  - sum, c_out and ovf are held stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE and clear out_valid.
  - sum, c_out and ovf keep their values until the next operation completes.
- Latency and throughput:
  - Operands accepted at edge E0 produce out_valid=1 after edge E0+NIBBLES.
  - Earliest next accept is the edge after the output handshake, so the minimum period is NIBBLES+2 cycles.
- Boundary conditions:
  - in_valid while ADD or DONE: ignored, no state change; the upstream must hold.
  - Changes on a, b or c_in after acceptance have no effect on the result.
  - NIBBLES=1: ADD lasts exactly one cycle.
- Arithmetic: unsigned modulo 2^W; {c_out, sum} = a + b + c_in exactly.

Test Plan:
- NIBBLES=4, a=16'h1234, b=16'h4321, c_in=0 -> after 4 ADD cycles: sum=16'h5555, c_out=0, ovf=0, out_valid=1 exactly 4 edges after accept.
- a=16'hFFFF, b=16'h0001, c_in=0 -> sum=16'h0000, c_out=1, ovf=0; carry ripples through all four nibble boundaries.
- a=16'h7FFF, b=16'h0001 -> sum=16'h8000, c_out=0, ovf=1. Then a=16'h8000, b=16'h8000 -> sum=16'h0000, c_out=1, ovf=1.
- a=16'h00FF, b=16'h0000, c_in=1 -> sum=16'h0100, c_out=0. Vectors then change during ADD -> result unchanged.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and new operands -> out_valid, sum, c_out and ovf are stable; in_ready=0; nothing accepted. out_ready=1 -> IDLE; the next accept occurs on the following edge.
- Reset: assert rst_n=0 mid-ADD (idx=2) -> outputs are immediately 0, in_ready=1. Rerun the NIBBLES=1 build: a=4'hF, b=4'h1 -> sum=4'h0, c_out=1, out_valid 1 edge after accept.
